// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state and owner encodings for the memory bus arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Plain-vector copies of the state encoding for legacy-style FSM code
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_RESP = RESP;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_LS   = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - fetch, LSU and memory handshake bundle seen by the arbiter
interface mem_bus_arbiter_if;

  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        o_if_err;

  logic        i_ls_req;
  logic [31:0] i_ls_addr;
  logic        i_ls_wren;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_ls_err;

  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wren;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  // Arbiter side: names carry the arbiter's own direction
  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    input  i_ls_req, i_ls_addr, i_ls_wren, i_ls_wdata, i_ls_bmask,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    output o_mem_req, o_mem_addr, o_mem_wren, o_mem_wdata, o_mem_bmask,
    input  i_mem_ack, i_mem_rdata
  );

  // Requesters and memory side
  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    output i_ls_req, i_ls_addr, i_ls_wren, i_ls_wdata, i_ls_bmask,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    input  o_mem_req, o_mem_addr, o_mem_wren, o_mem_wdata, o_mem_bmask,
    output i_mem_ack, i_mem_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// rtl/mem_bus_arbiter_watchdog.sv - request-phase watchdog with registered expire flag
module arb_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT_CYC);
  // Flag is raised one count early so it is visible in the cycle the count sits at TIMEOUT_CYC-1
  localparam logic [W-1:0] PRE_LAST = W'(TIMEOUT_CYC - 2);

  logic [W-1:0] cnt;

  // Count stalled request cycles; clearing outside REQ makes every entry start from zero
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt       <= '0;
      o_expired <= 1'b0;
    end else if (i_clr) begin
      cnt       <= '0;
      o_expired <= 1'b0;
    end else if (i_en) begin
      cnt       <= cnt + 1'b1;
      o_expired <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/LSU arbiter for a shared single-port memory
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC   = 16,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_bus_arbiter_if.slave   bus,
  output logic               o_busy,
  output logic [1:0]         o_owner
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  logic [1:0]    state;
  logic [SW-1:0] streak;
  logic [1:0]    owner;
  logic          arb_ok, gnt_if, gnt_ls, ack_hit, time_out, expired;

  logic          mem_req, mem_wren;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_bmask;
  logic          if_rvalid, if_err, ls_rvalid, ls_err;
  logic [31:0]   if_rdata, ls_rdata;

  // Grant decision: LSU first, fetch wins a tie once the LSU streak hits its limit
  always_comb begin
    arb_ok   = (state == ST_IDLE) || (state == ST_RESP);
    gnt_if   = arb_ok && bus.i_if_req && (!bus.i_ls_req || (streak == STREAK_MAX));
    gnt_ls   = arb_ok && bus.i_ls_req && !gnt_if;
    ack_hit  = (state == ST_REQ) && bus.i_mem_ack;
    time_out = (state == ST_REQ) && !bus.i_mem_ack && expired;
  end

  arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (state != ST_REQ),
    .i_en      ((state == ST_REQ) && !bus.i_mem_ack),
    .o_expired (expired)
  );

  // Transaction sequencing: grant -> REQ until ack or watchdog -> one RESP cycle
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (gnt_if || gnt_ls) state <= ST_REQ;
        ST_REQ:  if (ack_hit || time_out) state <= ST_RESP;
        ST_RESP: state <= (gnt_if || gnt_ls) ? ST_REQ : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // LSU streak only matters while fetch is waiting, so any idle fetch cycle resets it
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      streak <= '0;
    end else if (!bus.i_if_req || gnt_if) begin
      streak <= '0;
    end else if (gnt_ls && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

  // Latch the winner's request on grant so the memory sees stable fields through REQ
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wren  <= 1'b0;
      mem_wdata <= '0;
      mem_bmask <= '0;
    end else if (gnt_if || gnt_ls) begin
      mem_req   <= 1'b1;
      mem_addr  <= gnt_if ? bus.i_if_addr : bus.i_ls_addr;
      mem_wren  <= gnt_ls && bus.i_ls_wren;
      mem_wdata <= gnt_ls ? bus.i_ls_wdata : 32'h0;
      mem_bmask <= gnt_if ? 4'hF : bus.i_ls_bmask;
    end else if (ack_hit || time_out) begin
      mem_req   <= 1'b0;
    end
  end

  // Owner stays valid through RESP so the response can be routed, then returns to none
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      owner <= OWN_NONE;
    end else if (gnt_if || gnt_ls) begin
      owner <= gnt_if ? OWN_IF : OWN_LS;
    end else if (state == ST_RESP) begin
      owner <= OWN_NONE;
    end
  end

  // One-cycle response pulse to the owner; store data and timed-out data read as zero
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
      if (ack_hit || time_out) begin
        if (owner == OWN_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= (ack_hit && !mem_wren) ? bus.i_mem_rdata : 32'h0;
          if_err    <= time_out;
        end else begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= (ack_hit && !mem_wren) ? bus.i_mem_rdata : 32'h0;
          ls_err    <= time_out;
        end
      end
    end
  end

  assign bus.o_if_gnt    = gnt_if;
  assign bus.o_ls_gnt    = gnt_ls;
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wren  = mem_wren;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_bmask = mem_bmask;
  assign bus.o_if_rvalid = if_rvalid;
  assign bus.o_if_rdata  = if_rdata;
  assign bus.o_if_err    = if_err;
  assign bus.o_ls_rvalid = ls_rvalid;
  assign bus.o_ls_rdata  = ls_rdata;
  assign bus.o_ls_err    = ls_err;
  assign o_busy          = (state == ST_REQ);
  assign o_owner         = owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized and directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  import arb_pkg::*;

  localparam int TO   = 16;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [1:0] owner;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT_CYC(TO), .MAX_LS_STREAK(MAXS)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .bus     (bus),
    .o_busy  (busy),
    .o_owner (owner)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: whether a memory transaction is outstanding, which REQ cycle
  // it is in, whether a response is due this cycle, and the LSU streak.
  bit          m_in_req, m_resp;
  int          m_idx, m_ack_at, m_streak;
  logic [1:0]  m_owner;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wren, m_err;
  logic [3:0]  m_bmask;

  // Stimulus knobs
  int          fix_delay = 0;
  bit          spurious = 0;
  bit          hold_req = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_rdata = '0;

  // Observations from the last cycle
  int          obs_gnt;
  bit          obs_if_rv, obs_ls_rv;
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          req_hi_cnt;

  task automatic model_reset();
    m_in_req = 0; m_resp = 0; m_idx = 0; m_ack_at = 0; m_streak = 0;
    m_owner = OWN_NONE;
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(1, 3);
    if (r <= 7) return $urandom_range(4, 8);
    if (r == 8) return TO;
    return 40;
  endfunction

  // Advance one cycle: drive memory side, check DUT at negedge against model, step model.
  task automatic run_cycle();
    int w;
    bit nxt_resp;
    logic [31:0] rd;
    bus.i_mem_ack = m_in_req ? (m_idx == m_ack_at) : (spurious && ($urandom_range(0, 3) == 0));
    rd = use_fixed ? fixed_rdata : $urandom;
    bus.i_mem_rdata = rd;
    @(negedge clk);
    w = 0;
    if (!m_in_req) begin
      if (bus.i_if_req && bus.i_ls_req) w = (m_streak == MAXS) ? 1 : 2;
      else if (bus.i_if_req) w = 1;
      else if (bus.i_ls_req) w = 2;
    end
    n_vec++;
    if ({bus.o_if_gnt, bus.o_ls_gnt} !== {w == 1, w == 2}) begin
      n_err++; $display("FAIL grant: got if=%b ls=%b want if=%b ls=%b", bus.o_if_gnt, bus.o_ls_gnt, w == 1, w == 2);
    end
    n_vec++;
    if (bus.o_mem_req !== m_in_req || busy !== m_in_req) begin
      n_err++; $display("FAIL mem_req/busy: got %b/%b want %b", bus.o_mem_req, busy, m_in_req);
    end
    n_vec++;
    if (owner !== m_owner) begin
      n_err++; $display("FAIL owner: got %b want %b", owner, m_owner);
    end
    if (m_in_req) begin
      n_vec++;
      if (bus.o_mem_addr !== m_addr || bus.o_mem_wren !== m_wren || bus.o_mem_bmask !== m_bmask ||
          (m_owner == OWN_LS && bus.o_mem_wdata !== m_wdata)) begin
        n_err++; $display("FAIL mem_fields: got a=%h w=%b d=%h m=%h want a=%h w=%b d=%h m=%h",
          bus.o_mem_addr, bus.o_mem_wren, bus.o_mem_wdata, bus.o_mem_bmask, m_addr, m_wren, m_wdata, m_bmask);
      end
    end
    n_vec++;
    if ({bus.o_if_rvalid, bus.o_ls_rvalid} !== {m_resp && m_owner == OWN_IF, m_resp && m_owner == OWN_LS}) begin
      n_err++; $display("FAIL rvalid: got if=%b ls=%b want if=%b ls=%b", bus.o_if_rvalid, bus.o_ls_rvalid,
        m_resp && m_owner == OWN_IF, m_resp && m_owner == OWN_LS);
    end
    if (m_resp) begin
      n_vec++;
      if (m_owner == OWN_IF && (bus.o_if_rdata !== m_rdata || bus.o_if_err !== m_err)) begin
        n_err++; $display("FAIL if_resp: got d=%h e=%b want d=%h e=%b", bus.o_if_rdata, bus.o_if_err, m_rdata, m_err);
      end
      if (m_owner == OWN_LS && (bus.o_ls_rdata !== m_rdata || bus.o_ls_err !== m_err)) begin
        n_err++; $display("FAIL ls_resp: got d=%h e=%b want d=%h e=%b", bus.o_ls_rdata, bus.o_ls_err, m_rdata, m_err);
      end
    end
    obs_gnt   = bus.o_if_gnt ? 1 : (bus.o_ls_gnt ? 2 : 0);
    obs_if_rv = bus.o_if_rvalid;
    obs_ls_rv = bus.o_ls_rvalid;
    obs_rdata = bus.o_if_rvalid ? bus.o_if_rdata : bus.o_ls_rdata;
    obs_err   = bus.o_if_rvalid ? bus.o_if_err : bus.o_ls_err;
    if (bus.o_mem_req) req_hi_cnt++;
    nxt_resp = 0;
    if (m_in_req) begin
      if (bus.i_mem_ack) begin
        nxt_resp = 1; m_rdata = m_wren ? 32'h0 : rd; m_err = 0; m_in_req = 0;
      end else if (m_idx == TO) begin
        nxt_resp = 1; m_rdata = 32'h0; m_err = 1; m_in_req = 0;
      end else begin
        m_idx++;
      end
    end
    if (w != 0) begin
      m_in_req = 1; m_idx = 1;
      m_ack_at = (fix_delay != 0) ? fix_delay : pick_delay();
      m_owner  = (w == 1) ? OWN_IF : OWN_LS;
      m_addr   = (w == 1) ? bus.i_if_addr : bus.i_ls_addr;
      m_wren   = (w == 2) && bus.i_ls_wren;
      m_wdata  = bus.i_ls_wdata;
      m_bmask  = (w == 1) ? 4'hF : bus.i_ls_bmask;
    end else if (!m_in_req && !nxt_resp) begin
      m_owner = OWN_NONE;
    end
    m_resp = nxt_resp;
    if (!bus.i_if_req || w == 1) m_streak = 0;
    else if (w == 2 && m_streak < MAXS) m_streak++;
    @(posedge clk);
    #1;
    if (!hold_req && obs_gnt == 1) bus.i_if_req = 1'b0;
    if (!hold_req && obs_gnt == 2) bus.i_ls_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_in_req || m_resp || bus.i_if_req || bus.i_ls_req) && n < 300) begin
      run_cycle();
      n++;
    end
    n_vec++;
    if (n >= 300) begin
      n_err++; $display("FAIL drain_timeout: got %0d cycles want <300", n);
    end
  endtask

  task automatic test_reset();
    bus.i_if_req = 0; bus.i_if_addr = 0; bus.i_ls_req = 0; bus.i_ls_addr = 0;
    bus.i_ls_wren = 0; bus.i_ls_wdata = 0; bus.i_ls_bmask = 0;
    bus.i_mem_ack = 0; bus.i_mem_rdata = 0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.o_mem_req, bus.o_if_gnt, bus.o_ls_gnt, bus.o_if_rvalid, bus.o_ls_rvalid, busy, owner} !== 8'h00) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0", {bus.o_mem_req, bus.o_if_gnt, bus.o_ls_gnt,
        bus.o_if_rvalid, bus.o_ls_rvalid, busy, owner});
    end
    n_vec++;
    if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask, bus.o_mem_wren, bus.o_if_rdata, bus.o_ls_rdata} !== '0) begin
      n_err++; $display("FAIL reset_data: got a=%h d=%h want 0", bus.o_mem_addr, bus.o_mem_wdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch_single();
    int g, r;
    g = -1; r = -1;
    fix_delay = 2; use_fixed = 1; fixed_rdata = 32'hDEAD_BEEF; req_hi_cnt = 0;
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0010;
    for (int i = 0; i < 12 && r < 0; i++) begin
      run_cycle();
      if (obs_gnt == 1 && g < 0) g = i;
      if (obs_if_rv) begin r = i; end
    end
    n_vec++;
    if (g < 0 || r - g != 3) begin
      n_err++; $display("FAIL fetch_latency: got gnt=%0d rvalid=%0d want rvalid=gnt+3", g, r);
    end
    n_vec++;
    if (obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0 || req_hi_cnt != 2) begin
      n_err++; $display("FAIL fetch_data: got d=%h e=%b reqcyc=%0d want d=deadbeef e=0 reqcyc=2", obs_rdata, obs_err, req_hi_cnt);
    end
    use_fixed = 0;
    drain();
  endtask

  task automatic test_both_store();
    int first, seen;
    bit if_in_resp;
    first = 0; seen = 0; if_in_resp = 0;
    fix_delay = 2;
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0100;
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h0000_2000; bus.i_ls_wren = 1;
    bus.i_ls_wdata = 32'h1234_5678; bus.i_ls_bmask = 4'h3;
    for (int i = 0; i < 15 && !seen; i++) begin
      run_cycle();
      if (first == 0) first = obs_gnt;
      if (obs_ls_rv) begin seen = 1; if_in_resp = (obs_gnt == 1); end
    end
    n_vec++;
    if (first != 2 || !seen || !if_in_resp || obs_rdata !== 32'h0) begin
      n_err++; $display("FAIL both_store: got first=%0d rv=%0d ifgnt_in_resp=%0d d=%h want 2 1 1 0", first, seen, if_in_resp, obs_rdata);
    end
    bus.i_ls_wren = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    int seq[$];
    int n;
    fix_delay = 1; hold_req = 1;
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0040;
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h0000_3000; bus.i_ls_wren = 0; bus.i_ls_bmask = 4'hF;
    n = 0;
    while (seq.size() < 12 && n < 200) begin
      run_cycle();
      if (obs_gnt != 0) seq.push_back(obs_gnt);
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (i >= seq.size() || seq[i] != ((i % 5 == 4) ? 1 : 2)) begin
        n_err++; $display("FAIL streak_seq[%0d]: got %0d want %0d", i, (i < seq.size()) ? seq[i] : -1, (i % 5 == 4) ? 1 : 2);
      end
    end
    hold_req = 0;
    bus.i_if_req = 0; bus.i_ls_req = 0;
    drain();
  endtask

  task automatic test_timeout();
    bit seen;
    seen = 0;
    fix_delay = 40; req_hi_cnt = 0;
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h0000_4000; bus.i_ls_wren = 0; bus.i_ls_bmask = 4'hF;
    for (int i = 0; i < 40 && !seen; i++) begin
      run_cycle();
      if (obs_ls_rv) seen = 1;
    end
    n_vec++;
    if (!seen || req_hi_cnt != TO || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      n_err++; $display("FAIL timeout: got rv=%0d reqcyc=%0d e=%b d=%h want 1 16 1 0", seen, req_hi_cnt, obs_err, obs_rdata);
    end
    drain();
    seen = 0; fix_delay = 1; use_fixed = 1; fixed_rdata = 32'hA5A5_0001;
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h0000_4004;
    for (int i = 0; i < 10 && !seen; i++) begin
      run_cycle();
      if (obs_ls_rv) seen = 1;
    end
    n_vec++;
    if (!seen || obs_err !== 1'b0 || obs_rdata !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL after_timeout: got rv=%0d e=%b d=%h want 1 0 a5a50001", seen, obs_err, obs_rdata);
    end
    use_fixed = 0;
    drain();
  endtask

  task automatic test_ack_last();
    bit seen;
    seen = 0;
    fix_delay = TO; use_fixed = 1; fixed_rdata = 32'hCAFE_F00D; req_hi_cnt = 0;
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0080;
    for (int i = 0; i < 40 && !seen; i++) begin
      run_cycle();
      if (obs_if_rv) seen = 1;
    end
    n_vec++;
    if (!seen || obs_err !== 1'b0 || obs_rdata !== 32'hCAFE_F00D || req_hi_cnt != TO) begin
      n_err++; $display("FAIL ack_last: got rv=%0d e=%b d=%h reqcyc=%0d want 1 0 cafef00d 16", seen, obs_err, obs_rdata, req_hi_cnt);
    end
    use_fixed = 0;
    drain();
  endtask

  task automatic test_reset_mid();
    bit any_rv;
    any_rv = 0;
    fix_delay = 40;
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h0000_5000; bus.i_ls_wren = 0; bus.i_ls_bmask = 4'hF;
    repeat (4) run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.o_mem_req !== 1'b0 || busy !== 1'b0 || owner !== OWN_NONE) begin
      n_err++; $display("FAIL reset_mid: got req=%b busy=%b own=%b want 0 0 0", bus.o_mem_req, busy, owner);
    end
    bus.i_ls_req = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      run_cycle();
      if (obs_if_rv || obs_ls_rv) any_rv = 1;
    end
    n_vec++;
    if (any_rv) begin
      n_err++; $display("FAIL stale_rvalid: got 1 want 0");
    end
    fix_delay = 1;
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0200;
    run_cycle();
    n_vec++;
    if (obs_gnt != 1) begin
      n_err++; $display("FAIL post_reset_gnt: got %0d want 1", obs_gnt);
    end
    drain();
  endtask

  task automatic test_random();
    fix_delay = 0; spurious = 1;
    for (int i = 0; i < 800; i++) begin
      if (!bus.i_if_req && $urandom_range(0, 2) == 0) begin
        bus.i_if_req = 1; bus.i_if_addr = $urandom;
      end
      if (!bus.i_ls_req && $urandom_range(0, 1) == 0) begin
        bus.i_ls_req = 1; bus.i_ls_addr = $urandom; bus.i_ls_wren = $urandom_range(0, 1);
        bus.i_ls_wdata = $urandom; bus.i_ls_bmask = 4'($urandom_range(0, 15));
      end
      run_cycle();
    end
    spurious = 0;
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fetch_single();
    test_both_store();
    test_back_to_back();
    test_timeout();
    test_ack_last();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port instruction/data memory between the instruction-fetch requester and the load-store unit (LSU), for the multi-cycle core variant.
- Sequences each memory transaction as grant, then request held until acknowledge, then a response pulse.
- LSU has priority, with a fairness streak limit so fetch cannot starve.
- A watchdog terminates hung transactions with an error response.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles o_mem_req may stay high without i_mem_ack before an error response.
- MAX_LS_STREAK, 4: maximum consecutive LSU grants while fetch is waiting.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_if_req  in  1  fetch request; held with i_if_addr stable until o_if_gnt.
- i_if_addr  in  32  fetch address.
- o_if_gnt  out  1  fetch request accepted this cycle.
- o_if_rvalid  out  1  one-cycle fetch completion pulse.
- o_if_rdata  out  32  fetch data; valid with o_if_rvalid.
- o_if_err  out  1  fetch timed out; valid with o_if_rvalid.
- i_ls_req  in  1  LSU request; held with its address/data/mask/wren stable until o_ls_gnt.
- i_ls_addr  in  32  LSU address.
- i_ls_wren  in  1  1 = store, 0 = load.
- i_ls_wdata  in  32  store data.
- i_ls_bmask  in  4  byte-enable mask for stores.
- o_ls_gnt  out  1  LSU request accepted this cycle.
- o_ls_rvalid  out  1  one-cycle LSU completion pulse (loads and stores).
- o_ls_rdata  out  32  load data; 0 for stores.
- o_ls_err  out  1  LSU timed out.
- o_mem_req  out  1  memory request.
- o_mem_addr  out  32  memory address.
- o_mem_wren  out  1  memory write enable.
- o_mem_wdata  out  32  memory write data.
- o_mem_bmask  out  4  memory byte mask.
- i_mem_ack  in  1  memory completion, single cycle.
- i_mem_rdata  in  32  memory read data; valid with i_mem_ack.
- o_busy  out  1  1 while in REQ state.
- o_owner  out  2  current owner: 00 none, 01 fetch, 10 LSU.

Behaviour:
- Reset values: state IDLE; all outputs 0; streak and timeout counters 0.
  - Reset is async and effective mid-transaction: o_mem_req drops immediately and the outstanding transaction is discarded with no response.
- States:
  - IDLE: no transaction.
  - REQ: o_mem_req high; all o_mem_* fields held stable from registered copies.
  - RESP: exactly one cycle; owner's rvalid high.
- Arbitration occurs in IDLE and RESP only.
  - Grant is combinational from the req inputs and state.
  - The grant cycle latches addr/wren/wdata/bmask/owner; next state is REQ.
  - No request pending: IDLE→IDLE; RESP→IDLE.
- Priority rules:
  - Only one requester → that requester is granted.
  - Both requesting → LSU wins, unless streak == MAX_LS_STREAK, in which case fetch wins.
  - Streak increments on an LSU grant while i_if_req = 1, saturating at MAX_LS_STREAK.
  - Streak clears on any fetch grant, and on any cycle with i_if_req = 0.
  - Fetch requests force wren = 0 and bmask = 4'hF.
- REQ state:
  - Timeout counter is cleared on entry and increments each REQ cycle without ack.
  - i_mem_ack = 1: capture i_mem_rdata (0 if wren), err = 0, go to RESP.
  - Counter reaches TIMEOUT_CYC - 1 without ack: drop o_mem_req, rdata = 0, err = 1, go to RESP.
  - Ack and timeout in the same cycle: ack wins, err = 0.
- RESP state: owner's rvalid, rdata and err are registered outputs for one cycle; the other requester's rvalid stays 0.
- Latency:
  - Grant at cycle T; o_mem_req at T+1.
  - Ack at cycle T+k (k ≥ 1) → rvalid at T+k+1.
  - Next grant is possible at T+k+1, so back-to-back throughput is one transaction per k+1 cycles.
- Spurious i_mem_ack in IDLE or RESP is ignored.
- Requests are never dropped; a requester that is not granted simply keeps req high.

Decomposition:
- Package arb_pkg holds:
  - state enum {IDLE, REQ, RESP};
  - owner constants OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_LS = 2'b10.
- One natural sub-module, arb_watchdog: a cleared/enabled up-counter of width $clog2(TIMEOUT_CYC) with a registered expire flag.
- Arbitration and the streak counter stay in mem_bus_arbiter.

Test Plan:
- Fetch only, addr 0x0000_0010, mem acks 2 cycles after o_mem_req with rdata 0xDEAD_BEEF → o_if_gnt at T, o_mem_req at T+1..T+2, o_if_rvalid at T+3 with rdata 0xDEAD_BEEF, err 0.
- Fetch and LSU request together in IDLE, LSU store 0x1234_5678 to 0x0000_2000 with bmask 0x3 → o_ls_gnt first; o_mem_wren = 1, wdata/bmask match; o_ls_rvalid with rdata 0; then fetch granted in the RESP cycle.
- Both requests held continuously, immediate acks → grants in the sequence LS,LS,LS,LS,IF,LS…; streak resets after the IF grant.
- Memory never acks with TIMEOUT_CYC = 16 → o_mem_req high for exactly 16 cycles, then o_ls_rvalid with err = 1 and rdata 0; next request proceeds normally.
- Ack arrives exactly on the 16th REQ cycle → err = 0 and data returned.
- i_rst pulsed low while in REQ → o_mem_req = 0 immediately; no rvalid after release; first post-reset request is granted from IDLE.
